multi_mode_ff_bank: RTL

Parametrised bank of WIDTH edge-triggered flip-flops, each bit operating in a run-time-selectable SR, JK, D or T mode, with a synchronous active-high reset to a parameterised value. It generalises our single-bit SR flip-flop: it adds width, mode select, clock enable, a defined S=R=1 conflict policy, per-bit conflict flags, a saturating conflict counter and a change-detect pulse. It is used as the general state-holding primitive in the Day-series sequential blocks.

---
 rtl/ff_pkg.sv | 59 +++++
 rtl/ff_cell.sv | 56 +++++
 rtl/multi_mode_ff_bank.sv | 84 ++++++++
 3 files changed

// File: rtl/ff_pkg.sv
// Shared mode/policy definitions and the per-bit next-state rule for the
// multi-mode flip-flop bank.
package ff_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } ff_mode_e;

    localparam int POL_HOLD  = 0;
    localparam int POL_SET   = 1;
    localparam int POL_RESET = 2;

    // Next value of one flip-flop bit for an enabled edge.
    function automatic logic ff_next_bit(
        input ff_mode_e mode,
        input int       policy,
        input logic     a,
        input logic     b,
        input logic     q
    );
        logic nq;
        nq = q;
        case (mode)
            MODE_SR, MODE_JK: begin
                case ({a, b})
                    2'b00: nq = q;
                    2'b10: nq = 1'b1;
                    2'b01: nq = 1'b0;
                    2'b11: begin
                        if (mode == MODE_JK) begin
                            nq = ~q;
                        end else begin
                            case (policy)
                                POL_SET:   nq = 1'b1;
                                POL_RESET: nq = 1'b0;
                                default:   nq = q;
                            endcase
                        end
                    end
                    default: nq = q;
                endcase
            end
            MODE_D: nq = a;
            MODE_T: begin
                if (a) begin
                    nq = ~q;
                end else begin
                    nq = q;
                end
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/ff_cell.sv
// One bit of the bank: holds Q and the SR-conflict flag, and exposes the
// pending conflict/change so the top level can build its aggregate state.
module ff_cell
    import ff_pkg::*;
#(
    parameter int   POLICY    = POL_HOLD,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    output logic       q,
    output logic       conflict,
    output logic       conflict_next,
    output logic       q_change
);

    logic q_r;
    logic conflict_r;
    logic q_next_s;
    logic conflict_next_s;

    // Next-state and conflict evaluation; a disabled edge holds both.
    always_comb begin
        q_next_s        = q_r;
        conflict_next_s = conflict_r;
        if (en) begin
            q_next_s        = ff_next_bit(ff_mode_e'(mode), POLICY, a, b, q_r);
            conflict_next_s = (mode == MODE_SR) & a & b;
        end else begin
            q_next_s        = q_r;
            conflict_next_s = conflict_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r        <= RESET_BIT;
            conflict_r <= 1'b0;
        end else begin
            q_r        <= q_next_s;
            conflict_r <= conflict_next_s;
        end
    end

    assign q             = q_r;
    assign conflict      = conflict_r;
    // Only a conflict created on this enabled edge may bump the counter.
    assign conflict_next = conflict_next_s & en;
    assign q_change      = q_next_s ^ q_r;

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH run-time-mode flip-flops (SR/JK/D/T) with conflict flags,
// a saturating conflict counter and a change-detect pulse.
module multi_mode_ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}},
    parameter int               CONFLICT_POLICY = POL_HOLD,
    parameter int               ERR_W           = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] CONFLICT,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             CHANGED
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] conflict_s;
    logic [WIDTH-1:0] conflict_next_s;
    logic [WIDTH-1:0] q_change_s;
    logic             any_conflict_s;
    logic             any_change_s;
    logic [ERR_W-1:0] err_cnt_r;
    logic [ERR_W-1:0] err_cnt_next_s;
    logic             changed_r;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        ff_cell #(
            .POLICY    (CONFLICT_POLICY),
            .RESET_BIT (RESET_VAL[gi])
        ) u_cell (
            .clk           (CLK),
            .rst           (RST),
            .en            (EN),
            .mode          (MODE),
            .a             (A[gi]),
            .b             (B[gi]),
            .q             (q_s[gi]),
            .conflict      (conflict_s[gi]),
            .conflict_next (conflict_next_s[gi]),
            .q_change      (q_change_s[gi])
        );
    end

    assign any_conflict_s = |conflict_next_s;
    assign any_change_s   = |q_change_s;

    // Saturating increment of the conflict counter.
    always_comb begin
        err_cnt_next_s = err_cnt_r;
        if (any_conflict_s && (err_cnt_r != ERR_MAX)) begin
            err_cnt_next_s = err_cnt_r + ERR_W'(1'b1);
        end else begin
            err_cnt_next_s = err_cnt_r;
        end
    end

    // Counter and change-pulse registers; the reset edge never reports a change.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_r <= {ERR_W{1'b0}};
            changed_r <= 1'b0;
        end else begin
            err_cnt_r <= err_cnt_next_s;
            changed_r <= any_change_s;
        end
    end

    assign Q        = q_s;
    assign Qn       = ~q_s;
    assign CONFLICT = conflict_s;
    assign ERR_CNT  = err_cnt_r;
    assign CHANGED  = changed_r;

endmodule
